// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter merging ALU and memory-load results onto one register-bank write port
//
// Purpose:
//   Drives the single write port of the register bank (Rw, WE_Reg, dIN).
//   The ALU channel has absolute priority and cannot stall. Memory-load
//   results arrive on a valid/ready handshake and wait in a small FIFO.
//   At most one write is issued per cycle. Results addressed to x0 consume
//   their issue slot but never raise WE_Reg.
//
// Optional feature macro: WB_PENDING_EN
//   Adds output `pending`, one bit per register, high while a FIFO entry or
//   the registered output stage targets that register (bit 0 always 0).
//
// Ports:
//   clk, rst_n                      clock (rising edge), synchronous active-low reset
//   alu_valid, alu_rd, alu_data     ALU result, always accepted
//   mem_valid, mem_ready            load handshake (mem_ready is registered)
//   mem_rd, mem_data                load destination and value
//   Rw, WE_Reg, dIN                 registered bank write port
//   fifo_count                      buffered memory results
//   pending                         (WB_PENDING_EN only) per-register in-flight flags
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_rd,
    input  logic [DATA_W-1:0]          mem_data,
    output logic [ADDR_W-1:0]          Rw,
    output logic                       WE_Reg,
    output logic [DATA_W-1:0]          dIN,
`ifdef WB_PENDING_EN
    output logic [2**ADDR_W-1:0]       pending,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic push;
    logic pop;

    // ready_q only rises when count is below DEPTH, so a push never overflows.
    assign push = mem_valid && ready_q;
    // The ALU owns the slot whenever it is valid; the FIFO head simply waits.
    assign pop  = !alu_valid && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rw_d     = rw_q;
        din_d    = din_q;
        we_d     = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // x0 results still occupy the slot but never enable the write.
        if (alu_valid) begin
            rw_d  = alu_rd;
            din_d = alu_data;
            we_d  = (alu_rd != '0);
        end else if (pop) begin
            rw_d  = fifo_rd_q[rd_ptr_q];
            din_d = fifo_data_q[rd_ptr_q];
            we_d  = (fifo_rd_q[rd_ptr_q] != '0);
        end

        // No pass-through at full: ready stays low for a cycle even if a pop frees space.
        ready_d = (count_d < FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            rw_q     <= '0;
            we_q     <= 1'b0;
            din_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            rw_q     <= rw_d;
            we_q     <= we_d;
            din_q    <= din_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    assign mem_ready  = ready_q;
    assign fifo_count = count_q;
    assign Rw         = rw_q;
    assign WE_Reg     = we_q;
    assign dIN        = din_q;

`ifdef WB_PENDING_EN
    logic [2**ADDR_W-1:0] pending_c;

    // Derived from the registered FIFO and output stage, so it moves with them.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                pending_c[fifo_rd_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
            end
        end
        if (we_q) begin
            pending_c[rw_q] = 1'b1;
        end
        pending_c[0] = 1'b0;
    end

    assign pending = pending_c;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a queue-based reference model
module tb_wb_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic [ADDR_W-1:0] Rw;
    logic              WE_Reg;
    logic [DATA_W-1:0] dIN;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_PENDING_EN
    logic [2**ADDR_W-1:0] pending;
`endif

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .Rw         (Rw),
        .WE_Reg     (WE_Reg),
        .dIN        (dIN),
`ifdef WB_PENDING_EN
        .pending    (pending),
`endif
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model state: what the bank port should show after each edge.
    entry_t            q[$];
    logic              exp_we;
    logic [ADDR_W-1:0] exp_rw;
    logic [DATA_W-1:0] exp_din;
    logic              exp_ready;
    logic              last_acc;
    int                n_acc;
    int                compared = 0;
    int                mismatched = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue from the model: x0 uses the slot but produces no write.
    task automatic model_issue(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        exp_we = (rd != 0);
        if (rd != 0) begin
            exp_rw  = rd;
            exp_din = d;
        end
    endtask

    task automatic step(input logic rst, input logic av, input logic [ADDR_W-1:0] ard,
                        input logic [DATA_W-1:0] ad, input logic mv,
                        input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md);
        entry_t e;
        rst_n = ~rst; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        @(posedge clk);
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            exp_we = 0; exp_rw = 0; exp_din = 0; exp_ready = 1;
        end else begin
            last_acc = mv && exp_ready;
            if (av) begin
                model_issue(ard, ad);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                model_issue(e.rd, e.d);
            end else begin
                exp_we = 0;
            end
            if (last_acc) begin
                e.rd = mrd; e.d = md;
                q.push_back(e);
                n_acc++;
            end
            exp_ready = (q.size() < DEPTH);
        end
        #1;
        chk("WE_Reg", DATA_W'(WE_Reg), DATA_W'(exp_we));
        chk("fifo_count", DATA_W'(fifo_count), DATA_W'(q.size()));
        chk("mem_ready", DATA_W'(mem_ready), DATA_W'(exp_ready));
        if (exp_we) begin
            chk("Rw", DATA_W'(Rw), DATA_W'(exp_rw));
            chk("dIN", dIN, exp_din);
        end
`ifdef WB_PENDING_EN
        begin
            logic [2**ADDR_W-1:0] pexp;
            pexp = '0;
            foreach (q[i]) pexp[q[i].rd] = 1'b1;
            if (exp_we) pexp[exp_rw] = 1'b1;
            pexp[0] = 1'b0;
            chk("pending", DATA_W'(pending), DATA_W'(pexp));
        end
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] next_rd;
        n_acc = 0;
        exp_we = 0; exp_rw = 0; exp_din = 0; exp_ready = 1;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_Rw", DATA_W'(Rw), 0);
        chk("reset_dIN", dIN, 0);

        // ALU latency 1
        step(0, 1, 5, 64'hDEAD_BEEF, 0, 0, 0);
        chk("alu_we", DATA_W'(WE_Reg), 1);
        chk("alu_rw", DATA_W'(Rw), 5);
        chk("alu_din", dIN, 64'hDEAD_BEEF);
        idle();
        chk("alu_we_drop", DATA_W'(WE_Reg), 0);

        // Memory path: handshake, head, issue
        step(0, 0, 0, 0, 1, 7, 64'h1234);
        chk("mem_cnt1", DATA_W'(fifo_count), 1);
        chk("mem_we_early", DATA_W'(WE_Reg), 0);
        idle();
        chk("mem_we", DATA_W'(WE_Reg), 1);
        chk("mem_rw", DATA_W'(Rw), 7);
        chk("mem_din", dIN, 64'h1234);
        chk("mem_cnt0", DATA_W'(fifo_count), 0);

        // ALU starvation fills the FIFO; drain order 3,4,5,6 then the 5th result
        n_acc = 0;
        next_rd = 3;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 5'(20 + i), 64'(i), 1, next_rd, 64'(100 + next_rd));
            if (last_acc) next_rd++;
        end
        chk("starve_acc", 64'(n_acc), 4);
        chk("starve_cnt", DATA_W'(fifo_count), 4);
        chk("starve_ready", DATA_W'(mem_ready), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, next_rd <= 7, next_rd, 64'(100 + next_rd));
            if (last_acc) next_rd++;
            chk("drain_rw", DATA_W'(Rw), 64'(3 + i));
        end
        for (int i = 0; i < 4; i++) idle();
        chk("fifth_acc", 64'(n_acc), 5);

        // Register x0 on both channels
        step(0, 1, 0, 64'hFF, 1, 0, 64'h55);
        chk("x0_alu_we", DATA_W'(WE_Reg), 0);
        idle();
        chk("x0_mem_we", DATA_W'(WE_Reg), 0);
        chk("x0_cnt", DATA_W'(fifo_count), 0);

        // Reset with three buffered entries
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 5'(10 + i), 64'(i));
        chk("pre_rst_cnt", DATA_W'(fifo_count), 3);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt", DATA_W'(fifo_count), 0);
        chk("rst_we", DATA_W'(WE_Reg), 0);
        chk("rst_ready", DATA_W'(mem_ready), 1);
        for (int i = 0; i < 4; i++) idle();

`ifdef WB_PENDING_EN
        // Queue rd=9 while the ALU writes rd=2
        step(0, 1, 2, 64'h22, 1, 9, 64'h99);
        chk("pend9", DATA_W'(pending[9]), 1);
        chk("pend2", DATA_W'(pending[2]), 1);
        idle();
        chk("pend2_clr", DATA_W'(pending[2]), 0);
        chk("pend9_out", DATA_W'(pending[9]), 1);
        idle();
        chk("pend9_clr", DATA_W'(pending[9]), 0);
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 45,
                 ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
                 {$urandom, $urandom},
                 $urandom_range(0, 99) < 60,
                 ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
                 {$urandom, $urandom});
        end
        for (int i = 0; i < 6; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
